// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types, constants and helpers for score_keeper
package score_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [NUM_DIGITS-1:0] bcd6_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_COMMIT} fsm_state_t;

    localparam bcd6_t PTS_POINT      = 24'h000010;
    localparam bcd6_t PTS_PELLET     = 24'h000050;
    localparam bcd6_t PTS_GHOST_BASE = 24'h000200;
    localparam bcd6_t BCD_MAX        = 24'h999999;
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    localparam logic [1:0] SPR_1 = 2'b00;
    localparam logic [1:0] SPR_U = 2'b01;
    localparam logic [1:0] SPR_P = 2'b10;

    function automatic bcd6_t ghost_points(input logic [1:0] combo);
        case (combo)
            2'd0:    return PTS_GHOST_BASE;
            2'd1:    return 24'h000400;
            2'd2:    return 24'h000800;
            default: return 24'h001600;
        endcase
    endfunction

    // Capture and consume in the same cycle cancel out.
    function automatic logic [1:0] pend_next(input logic [1:0] cnt, input logic inc,
                                             input logic dec);
        if (inc && !dec) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
        if (dec && !inc) return cnt - 2'd1;
        return cnt;
    endfunction

    function automatic logic [2:0] col12(input logic [9:0] off);
        if (off >= 10'd60) return 3'd5;
        if (off >= 10'd48) return 3'd4;
        if (off >= 10'd36) return 3'd3;
        if (off >= 10'd24) return 3'd2;
        if (off >= 10'd12) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic digit_shown(input bcd6_t v, input logic [2:0] idx);
        logic r;
        r = (idx <= 3'd1);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((3'(i) >= idx) && (v[i] != 4'd0)) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - game-event and pixel-query bundle for score_keeper
interface score_keeper_if;
    import score_pkg::*;

    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       new_game;
    logic       game_active;
    logic       ate_point;
    logic       ate_pellet;
    logic       ate_ghost;
    logic       score_busy;
    logic       is_scoreboard;
    bcd_digit_t scoreboard_sprite;
    logic       is_scoreboard_1up;
    logic [1:0] scoreboard_1up_sprite;

    modport master (
        output DrawX, DrawY, new_game, game_active, ate_point, ate_pellet, ate_ghost,
        input  score_busy, is_scoreboard, scoreboard_sprite, is_scoreboard_1up,
               scoreboard_1up_sprite
    );

    modport slave (
        input  DrawX, DrawY, new_game, game_active, ate_point, ate_pellet, ate_ghost,
        output score_busy, is_scoreboard, scoreboard_sprite, is_scoreboard_1up,
               scoreboard_1up_sprite
    );

endinterface

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single BCD digit adder with carry
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t i_a,
    input  bcd_digit_t i_b,
    input  logic       i_cin,
    output bcd_digit_t o_sum,
    output logic       o_cout
);
    logic [4:0] w_raw;

    always_comb begin
        w_raw  = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_cin};
        o_cout = (w_raw > 5'd9);
        o_sum  = o_cout ? (w_raw[3:0] - 4'd10) : w_raw[3:0];
    end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - BCD score/high-score keeper with digit-serial adder and scoreboard pixel decode
module score_keeper
    import score_pkg::*;
#(
    parameter logic [9:0]  SCORE_X      = 10'd48,
    parameter logic [9:0]  HI_X         = 10'd216,
    parameter logic [9:0]  SCORE_Y      = 10'd30,
    parameter logic [9:0]  UP_X         = 10'd36,
    parameter logic [9:0]  UP_Y         = 10'd12,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input logic           Clk,
    input logic           Reset_n,
    input logic           frame_clk,
    score_keeper_if.slave bus
);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    fsm_state_t r_state, w_state_next;
    bcd6_t      r_score, r_hi, r_acc, r_addend, w_commit;
    logic       r_carry;
    logic [2:0] r_digit;
    logic [1:0] r_pend_point, r_pend_pellet, r_pend_ghost, r_combo;
    logic       w_take_point, w_take_pellet, w_take_ghost;
    bcd_digit_t w_dsum;
    logic       w_dcout;

    bcd_digit_add u_add (
        .i_a    (r_acc[r_digit]),
        .i_b    (r_addend[r_digit]),
        .i_cin  (r_carry),
        .o_sum  (w_dsum),
        .o_cout (w_dcout)
    );

    assign w_commit = r_carry ? BCD_MAX : r_acc;

    always_ff @(posedge Clk) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_take_pellet = 1'b0;
        w_take_ghost  = 1'b0;
        w_take_point  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_pend_point | r_pend_pellet | r_pend_ghost) != 2'd0) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next  = S_ADD;
                w_take_pellet = (r_pend_pellet != 2'd0);
                w_take_ghost  = !w_take_pellet && (r_pend_ghost != 2'd0);
                w_take_point  = !w_take_pellet && !w_take_ghost && (r_pend_point != 2'd0);
            end
            S_ADD: begin
                if (r_digit == LAST_DIGIT) w_state_next = S_COMMIT;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (bus.new_game) w_state_next = S_IDLE;
    end

    // The shadow accumulator is private; only COMMIT touches the displayed score.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_score       <= '0;
            r_hi          <= '0;
            r_acc         <= '0;
            r_addend      <= '0;
            r_carry       <= 1'b0;
            r_digit       <= 3'd0;
            r_pend_point  <= 2'd0;
            r_pend_pellet <= 2'd0;
            r_pend_ghost  <= 2'd0;
            r_combo       <= 2'd0;
        end else if (bus.new_game) begin
            r_score       <= '0;
            r_pend_point  <= 2'd0;
            r_pend_pellet <= 2'd0;
            r_pend_ghost  <= 2'd0;
            r_combo       <= 2'd0;
        end else begin
            r_pend_point  <= pend_next(r_pend_point, bus.ate_point, w_take_point);
            r_pend_pellet <= pend_next(r_pend_pellet, bus.ate_pellet, w_take_pellet);
            r_pend_ghost  <= pend_next(r_pend_ghost, bus.ate_ghost, w_take_ghost);
            case (r_state)
                S_LOAD: begin
                    r_acc   <= r_score;
                    r_carry <= 1'b0;
                    r_digit <= 3'd0;
                    if (w_take_pellet) begin
                        r_addend <= PTS_PELLET;
                        r_combo  <= 2'd0;
                    end else if (w_take_ghost) begin
                        r_addend <= ghost_points(r_combo);
                        r_combo  <= (r_combo == 2'd3) ? r_combo : r_combo + 2'd1;
                    end else begin
                        r_addend <= PTS_POINT;
                    end
                end
                S_ADD: begin
                    r_acc[r_digit] <= w_dsum;
                    r_carry        <= w_dcout;
                    r_digit        <= r_digit + 3'd1;
                end
                S_COMMIT: begin
                    r_score <= w_commit;
                    // Packed BCD compares like the decimal value, MSD first.
                    if (w_commit > r_hi) r_hi <= w_commit;
                end
                default: ;
            endcase
        end
    end

    logic       r_f1, r_f2, r_visible;
    logic [7:0] r_blink_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_f1        <= 1'b0;
            r_f2        <= 1'b0;
            r_blink_cnt <= 8'd0;
            r_visible   <= 1'b1;
        end else begin
            r_f1 <= frame_clk;
            r_f2 <= r_f1;
            if (!bus.game_active) begin
                r_blink_cnt <= 8'd0;
                r_visible   <= 1'b1;
            end else if (bus.new_game) begin
                r_blink_cnt <= 8'd0;
            end else if (r_f1 && !r_f2) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= 8'd0;
                    r_visible   <= !r_visible;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
        end
    end

    logic [9:0] w_s_off, w_h_off, w_u_off;
    logic       w_in_row, w_in_score, w_in_hi, w_in_up;
    logic [2:0] w_s_idx, w_h_idx;
    logic       w_pix_is, w_up_is;
    bcd_digit_t w_pix_spr;
    logic [1:0] w_up_spr;

    always_comb begin
        w_s_off    = bus.DrawX - SCORE_X;
        w_h_off    = bus.DrawX - HI_X;
        w_u_off    = bus.DrawX - UP_X;
        w_in_row   = (bus.DrawY >= SCORE_Y) && (bus.DrawY < SCORE_Y + 10'd12);
        w_in_score = w_in_row && (bus.DrawX >= SCORE_X) && (bus.DrawX < SCORE_X + 10'd72);
        w_in_hi    = w_in_row && (bus.DrawX >= HI_X) && (bus.DrawX < HI_X + 10'd72);
        w_in_up    = (bus.DrawY >= UP_Y) && (bus.DrawY < UP_Y + 10'd12) &&
                     (bus.DrawX >= UP_X) && (bus.DrawX < UP_X + 10'd36);
        w_s_idx    = LAST_DIGIT - col12(w_s_off);
        w_h_idx    = LAST_DIGIT - col12(w_h_off);
        w_pix_is   = 1'b0;
        w_pix_spr  = 4'd0;
        if (w_in_score) begin
            w_pix_spr = r_score[w_s_idx];
            w_pix_is  = digit_shown(r_score, w_s_idx);
        end else if (w_in_hi) begin
            w_pix_spr = r_hi[w_h_idx];
            w_pix_is  = digit_shown(r_hi, w_h_idx);
        end
        w_up_spr = 2'b00;
        if (w_in_up) begin
            w_up_spr = (w_u_off >= 10'd24) ? SPR_P : (w_u_off >= 10'd12) ? SPR_U : SPR_1;
        end
        w_up_is = w_in_up && r_visible;
    end

    logic       r_pix_is, r_up_is;
    bcd_digit_t r_pix_spr;
    logic [1:0] r_up_spr;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_pix_is  <= 1'b0;
            r_pix_spr <= 4'd0;
            r_up_is   <= 1'b0;
            r_up_spr  <= 2'b00;
        end else begin
            r_pix_is  <= w_pix_is;
            r_pix_spr <= w_pix_spr;
            r_up_is   <= w_up_is;
            r_up_spr  <= w_up_spr;
        end
    end

    assign bus.score_busy            = (r_state != S_IDLE);
    assign bus.is_scoreboard         = r_pix_is;
    assign bus.scoreboard_sprite     = r_pix_spr;
    assign bus.is_scoreboard_1up     = r_up_is;
    assign bus.scoreboard_1up_sprite = r_up_spr;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed vector bench for score_keeper
module tb_score_keeper;
    import score_pkg::*;

    localparam logic [9:0] SCORE_X = 10'd48;
    localparam logic [9:0] HI_X    = 10'd216;
    localparam logic [9:0] SCORE_Y = 10'd30;
    localparam logic [9:0] UP_X    = 10'd36;
    localparam logic [9:0] UP_Y    = 10'd12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic fclk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    score_keeper_if bus();

    score_keeper dut (
        .Clk       (clk),
        .Reset_n   (rstn),
        .frame_clk (fclk),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       is_sb;
        logic [3:0] spr;
        logic       is_up;
        logic [1:0] up_spr;
    } pix_vec_t;

    pix_vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] exp_shown(input logic [23:0] v);
        logic [5:0] m;
        logic seen;
        seen = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (v[4*i +: 4] != 4'd0) seen = 1'b1;
            m[i] = seen || (i <= 1);
        end
        return m;
    endfunction

    task automatic read_field(input logic [9:0] base, output logic [23:0] val,
                              output logic [5:0] shown);
        for (int c = 0; c < 6; c++) begin
            bus.DrawX = base + 10'(12 * c);
            bus.DrawY = SCORE_Y;
            step();
            val[4*(5-c) +: 4] = bus.scoreboard_sprite;
            shown[5-c]        = bus.is_scoreboard;
        end
    endtask

    task automatic check_scores(input string nm, input int s, input int h);
        logic [23:0] v;
        logic [5:0]  m;
        read_field(SCORE_X, v, m);
        chk({nm, " score"}, 32'(v), 32'(to_bcd(s)));
        chk({nm, " score_blank"}, 32'(m), 32'(exp_shown(to_bcd(s))));
        read_field(HI_X, v, m);
        chk({nm, " hi"}, 32'(v), 32'(to_bcd(h)));
        chk({nm, " hi_blank"}, 32'(m), 32'(exp_shown(to_bcd(h))));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.score_busy && n < 50) begin
            step();
            n++;
        end
        if (bus.score_busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: score_busy=1 required 0 within 50 cycles");
        end
    endtask

    task automatic ev(input logic p, input logic pel, input logic g);
        bus.ate_point  = p;
        bus.ate_pellet = pel;
        bus.ate_ghost  = g;
        step();
        bus.ate_point  = 1'b0;
        bus.ate_pellet = 1'b0;
        bus.ate_ghost  = 1'b0;
        step();
        wait_idle();
    endtask

    task automatic pulse_new_game();
        bus.new_game = 1'b1;
        step();
        bus.new_game = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy_n;
        int exp_s, exp_h, combo, g;
        bus.DrawX       = SCORE_X + 10'd60;
        bus.DrawY       = SCORE_Y;
        bus.new_game    = 1'b0;
        bus.game_active = 1'b0;
        bus.ate_point   = 1'b0;
        bus.ate_pellet  = 1'b0;
        bus.ate_ghost   = 1'b0;

        vecs[0]  = '{SCORE_X + 10'd60, SCORE_Y,         1'b1, 4'd0, 1'b0, 2'd0};
        vecs[1]  = '{SCORE_X + 10'd48, SCORE_Y + 10'd11, 1'b1, 4'd1, 1'b0, 2'd0};
        vecs[2]  = '{SCORE_X + 10'd36, SCORE_Y,         1'b0, 4'd0, 1'b0, 2'd0};
        vecs[3]  = '{SCORE_X,          SCORE_Y + 10'd5,  1'b0, 4'd0, 1'b0, 2'd0};
        vecs[4]  = '{SCORE_X + 10'd71, SCORE_Y,         1'b1, 4'd0, 1'b0, 2'd0};
        vecs[5]  = '{SCORE_X + 10'd72, SCORE_Y,         1'b0, 4'd0, 1'b0, 2'd0};
        vecs[6]  = '{SCORE_X + 10'd60, SCORE_Y - 10'd1,  1'b0, 4'd0, 1'b0, 2'd0};
        vecs[7]  = '{SCORE_X + 10'd60, SCORE_Y + 10'd12, 1'b0, 4'd0, 1'b0, 2'd0};
        vecs[8]  = '{HI_X + 10'd60,    SCORE_Y,         1'b1, 4'd0, 1'b0, 2'd0};
        vecs[9]  = '{HI_X + 10'd48,    SCORE_Y,         1'b1, 4'd1, 1'b0, 2'd0};
        vecs[10] = '{HI_X + 10'd36,    SCORE_Y,         1'b0, 4'd0, 1'b0, 2'd0};
        vecs[11] = '{UP_X,             UP_Y,            1'b0, 4'd0, 1'b1, 2'b00};
        vecs[12] = '{UP_X + 10'd12,    UP_Y,            1'b0, 4'd0, 1'b1, 2'b01};
        vecs[13] = '{UP_X + 10'd35,    UP_Y + 10'd11,   1'b0, 4'd0, 1'b1, 2'b10};
        vecs[14] = '{UP_X + 10'd36,    UP_Y,            1'b0, 4'd0, 1'b0, 2'b00};
        vecs[15] = '{UP_X,             UP_Y + 10'd12,   1'b0, 4'd0, 1'b0, 2'b00};

        step();
        step();
        chk("reset busy", 32'(bus.score_busy), 32'd0);
        chk("reset is_sb", 32'(bus.is_scoreboard), 32'd0);
        chk("reset spr", 32'(bus.scoreboard_sprite), 32'd0);
        chk("reset is_up", 32'(bus.is_scoreboard_1up), 32'd0);
        rstn = 1'b1;
        step();
        step();
        chk("post_reset lsd shown", 32'(bus.is_scoreboard), 32'd1);
        check_scores("reset", 0, 0);

        bus.ate_point = 1'b1;
        step();
        bus.ate_point = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.score_busy) busy_n++;
        end
        chk("point busy_cycles", 32'(busy_n), 32'd8);
        check_scores("point", 10, 10);

        for (int i = 0; i < 16; i++) begin
            bus.DrawX = vecs[i].x;
            bus.DrawY = vecs[i].y;
            step();
            chk($sformatf("vec%0d is_sb", i), 32'(bus.is_scoreboard), 32'(vecs[i].is_sb));
            chk($sformatf("vec%0d spr", i), 32'(bus.scoreboard_sprite), 32'(vecs[i].spr));
            chk($sformatf("vec%0d is_up", i), 32'(bus.is_scoreboard_1up), 32'(vecs[i].is_up));
            chk($sformatf("vec%0d up_spr", i), 32'(bus.scoreboard_1up_sprite), 32'(vecs[i].up_spr));
        end

        pulse_new_game();
        check_scores("new_game", 0, 10);
        ev(1'b0, 1'b1, 1'b0);
        check_scores("pellet", 50, 50);
        for (int i = 0; i < 5; i++) begin
            ev(1'b0, 1'b0, 1'b1);
            repeat (10) step();
        end
        check_scores("ghosts", 4650, 4650);

        do_reset();
        bus.ate_point  = 1'b1;
        bus.ate_pellet = 1'b1;
        bus.ate_ghost  = 1'b1;
        step();
        bus.ate_point  = 1'b0;
        bus.ate_pellet = 1'b0;
        bus.ate_ghost  = 1'b0;
        repeat (40) step();
        chk("simul idle", 32'(bus.score_busy), 32'd0);
        check_scores("simul", 260, 260);
        ev(1'b0, 1'b0, 1'b1);
        check_scores("combo", 660, 660);

        do_reset();
        for (int i = 0; i < 10; i++) ev(1'b1, 1'b0, 1'b0);
        check_scores("hundred", 100, 100);
        bus.ate_point = 1'b1;
        step();
        bus.ate_point = 1'b0;
        repeat (4) step();
        bus.new_game = 1'b1;
        step();
        bus.new_game = 1'b0;
        chk("abort busy", 32'(bus.score_busy), 32'd0);
        repeat (20) step();
        chk("abort late busy", 32'(bus.score_busy), 32'd0);
        check_scores("abort", 0, 100);

        exp_s = 0;
        exp_h = 100;
        combo = 0;
        for (int i = 0; i < 630; i++) begin
            ev(1'b0, 1'b0, 1'b1);
            g     = 200 << combo;
            exp_s = (exp_s + g > 999999) ? 999999 : exp_s + g;
            combo = (combo == 3) ? 3 : combo + 1;
            exp_h = (exp_s > exp_h) ? exp_s : exp_h;
            if (i == 623) check_scores("sat_mid", exp_s, exp_h);
        end
        check_scores("sat_ghost", 999999, 999999);
        ev(1'b0, 1'b1, 1'b0);
        check_scores("sat_pellet", 999999, 999999);

        bus.DrawX       = UP_X + 10'd12;
        bus.DrawY       = UP_Y;
        bus.game_active = 1'b1;
        step();
        for (int n = 1; n <= 40; n++) begin
            fclk = 1'b1;
            repeat (2) step();
            fclk = 1'b0;
            repeat (3) step();
            chk($sformatf("blink edge%0d", n), 32'(bus.is_scoreboard_1up),
                32'(((n / 16) % 2) == 0));
            chk($sformatf("blink spr%0d", n), 32'(bus.scoreboard_1up_sprite), 32'd1);
        end
        bus.game_active = 1'b0;
        repeat (3) step();
        chk("steady on", 32'(bus.is_scoreboard_1up), 32'd1);
        for (int n = 0; n < 3; n++) begin
            fclk = 1'b1;
            repeat (2) step();
            fclk = 1'b0;
            repeat (3) step();
            chk($sformatf("steady edge%0d", n), 32'(bus.is_scoreboard_1up), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream of color_mapper. Accumulates the game score from eat events and tracks the high score, both as 6-digit BCD.
- Per pixel, drives is_scoreboard / scoreboard_sprite (digits) and is_scoreboard_1up / scoreboard_1up_sprite (blinking "1UP" label).
- Scoring arithmetic is digit-serial on a shadow accumulator. The display only ever sees committed values.

Parameters:
- NUM_DIGITS, 6, BCD digits per score.
- SCORE_X, 48, left X of current-score field; multiple of 12.
- HI_X, 216, left X of high-score field; multiple of 12.
- SCORE_Y, 30, top Y of both score fields; (SCORE_Y+6)%12==0.
- UP_X, 36, left X of "1UP" label; multiple of 12.
- UP_Y, 12, top Y of label; multiple of 12.
- BLINK_FRAMES, 16, frames per 1UP on/off phase.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous, active-low reset.
- frame_clk  in  1  vsync-rate strobe; rising edge detected internally.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- new_game  in  1  1-cycle pulse; clear score, keep high score.
- game_active  in  1  1 = 1UP blinks; 0 = 1UP steady on.
- ate_point  in  1  1-cycle pulse, +10.
- ate_pellet  in  1  1-cycle pulse, +50, resets ghost combo.
- ate_ghost  in  1  1-cycle pulse, +200/400/800/1600.
- score_busy  out  1  FSM not in IDLE.
- is_scoreboard  out  1  pixel lies on a visible score digit.
- scoreboard_sprite  out  4  digit value 0-9 for this pixel.
- is_scoreboard_1up  out  1  pixel lies on a visible 1UP cell.
- scoreboard_1up_sprite  out  2  00='1', 01='U', 10='P'.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - score, hi_score, shadow accumulator, pending counters, combo and blink counter all 0.
  - FSM=IDLE; all outputs 0.
- Event capture:
  - Each of point, pellet and ghost has a 2-bit saturating pending counter. A pulse increments it (stays at 3).
  - Simultaneous pulses are each counted.
  - A capture in the same cycle as the FSM consuming that type nets to no change.
- FSM states: IDLE -> LOAD -> ADD (NUM_DIGITS cycles) -> COMMIT -> IDLE.
  - IDLE: if any pending counter is nonzero, go to LOAD.
  - LOAD: select the type by priority pellet > ghost > point, then decrement that counter.
    - Build the BCD addend: point 000010; pellet 000050, and combo<=0; ghost 000200<<combo in value (200, 400, 800, 1600), and combo<=min(combo+1,3).
    - Copy score into the shadow accumulator; clear carry.
  - ADD: digit i = i-th cycle, LSD first. sum = acc[i]+addend[i]+carry; if sum>9, write sum-10 and set carry=1, else carry=0.
  - COMMIT: if the final carry is 1, saturate to 999999. Write score<=shadow.
    - If the new score > hi_score (BCD compare, MSD first), set hi_score<=new score in the same cycle.
- Latency: one event takes 1+NUM_DIGITS+1 = 8 cycles from leaving IDLE to the committed score.
- new_game:
  - Clears score, pending counters, combo and blink counter; FSM to IDLE. Aborts any in-flight add, whose result is discarded.
  - hi_score is unchanged.
  - A simultaneous ate_* pulse in the same cycle is dropped.
- 1UP blink:
  - Count frame_clk rising edges (2-flop synchronised edge detect).
  - While game_active, toggle a visible flag every BLINK_FRAMES edges.
  - While !game_active, flag=1 and the counter is held at 0.
- Pixel outputs (registered, 1-cycle latency from DrawX/DrawY):
  - Score field: DrawY in [SCORE_Y, SCORE_Y+12), DrawX in [SCORE_X, SCORE_X+72). Digit index = 5-(DrawX-SCORE_X)/12 (MSD leftmost); scoreboard_sprite = that digit.
  - Same rule for the HI field at HI_X using hi_score.
  - Leading-zero blanking: is_scoreboard=0 for zero digits left of the most significant nonzero digit. Digits 0 and 1 are always shown, so an empty score reads "00".
  - 1UP field: DrawY in [UP_Y, UP_Y+12), DrawX in [UP_X, UP_X+36). scoreboard_1up_sprite = (DrawX-UP_X)/12; is_scoreboard_1up = in field && visible.
  - Outside all fields, all four pixel outputs are 0.
- Displayed values change only at COMMIT, never mid-add.

Decomposition:
- Package score_pkg: BCD digit typedef; bcd6 array typedef; fsm_state_t enum; addend constants PTS_POINT/PTS_PELLET/PTS_GHOST_BASE; sprite codes for 1, U and P.
- Sub-module bcd_digit_add (4b a, 4b b, carry in -> 4b sum, carry out), instantiated once and time-multiplexed across digits.
- Pixel-field decode stays in the top module.

Test Plan:
- Reset, then one ate_point pulse -> score_busy high 8 cycles; score=000010; hi=000010; pixel at (SCORE_X+60, SCORE_Y) gives sprite=0, is_scoreboard=1; the digit at SCORE_X+48 gives 1; leading digits blanked.
- ate_pellet then 5 ate_ghost pulses spaced 20 cycles -> score 50+200+400+800+1600+1600 = 4650.
- ate_point, ate_pellet and ate_ghost pulsed in the same cycle from reset -> processed pellet, ghost(200), point; final score 260; combo=1.
- Preload near max via repeated events (or force 999990), then ate_pellet -> score saturates at 999999; hi=999999.
- Score 000100, then new_game asserted 3 cycles into an add -> score=0 ("00" shown); hi stays 000100; no late commit.
- game_active=1, 40 frame_clk edges -> is_scoreboard_1up at (UP_X+12, UP_Y) toggles after edges 16 and 32 with sprite=01; game_active=0 -> steady 1.
